// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch sequencer states
//   INSTR_BYTES   : size of one instruction word in bytes (PC step)
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads the PC from the register file, issues one
// single-word read per instruction, buffers the returned word for decode
// and writes PC+4 back. Handles the boot PC load, redirects and faults.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_pc                         current PC from the register file
//   o_load_pc, o_load_pc_data    PC write strobe/value to the register file
//   o_mem_req, o_mem_addr        instruction read request and address
//   i_mem_ack, i_mem_data        read completion and data
//   i_mem_err                    bus error, qualified by i_mem_ack
//   o_instr_valid, o_instr,
//   o_instr_pc, i_instr_ready    buffered instruction handshake to decode
//   i_redirect, i_redirect_pc    PC change request from execute
//   o_fault, o_fault_pc          pending fetch fault and its address
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_load_pc,
  output logic [31:0] o_load_pc_data,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_err,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fault_pc;

  // Unsigned add wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  logic [31:0] seq_pc;
  assign seq_pc = mem_addr + INSTR_BYTES;

  logic misaligned;
  assign misaligned = (i_pc[1:0] != 2'b00);

  // Next state and the PC write port. The register file samples the load on
  // the same edge that moves the state, so this is purely combinational.
  always_comb begin
    state_next     = state;
    o_load_pc      = 1'b0;
    o_load_pc_data = i_redirect_pc;
    case (state)
      ST_BOOT: begin
        o_load_pc      = 1'b1;
        o_load_pc_data = RESET_PC;
        state_next     = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (i_redirect) begin
          o_load_pc = 1'b1;
        end else if (misaligned) begin
          state_next = ST_FAULT;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_redirect) begin
          o_load_pc  = 1'b1;
          // Without the ack in hand the response is still in flight and
          // must be swallowed before the next request can go out.
          state_next = i_mem_ack ? ST_ISSUE : ST_DRAIN;
        end else if (i_mem_ack && i_mem_err) begin
          state_next = ST_FAULT;
        end else if (i_mem_ack) begin
          o_load_pc      = 1'b1;
          o_load_pc_data = seq_pc;
          state_next     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_redirect) begin
          o_load_pc  = 1'b1;
          state_next = ST_ISSUE;
        end else if (i_instr_ready) begin
          state_next = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // A redirect here only rewrites the PC; leaving still depends on the
        // outstanding ack, otherwise the bus would be left mid-transaction.
        if (i_redirect) begin
          o_load_pc = 1'b1;
        end
        if (i_mem_ack) begin
          state_next = ST_ISSUE;
        end
      end
      ST_FAULT: begin
        if (i_redirect) begin
          o_load_pc  = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_BOOT;
      mem_addr <= 32'h0;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
      fault_pc <= 32'h0;
    end else begin
      state <= state_next;
      if (state == ST_ISSUE && !i_redirect) begin
        if (misaligned) begin
          fault_pc <= i_pc;
        end else begin
          mem_addr <= i_pc;
        end
      end
      if (state == ST_WAIT && !i_redirect && i_mem_ack) begin
        if (i_mem_err) begin
          fault_pc <= mem_addr;
        end else begin
          instr    <= i_mem_data;
          instr_pc <= mem_addr;
        end
      end
    end
  end

  assign o_mem_req     = (state == ST_WAIT) || (state == ST_DRAIN);
  assign o_instr_valid = (state == ST_HOLD);
  assign o_fault       = (state == ST_FAULT);
  assign o_mem_addr    = mem_addr;
  assign o_instr       = instr;
  assign o_instr_pc    = instr_pc;
  assign o_fault_pc    = fault_pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit of the core, sitting directly upstream of the register file's program counter. Each cycle it reads the current PC, issues a single-word instruction read to memory, and buffers the returned word for decode. On completion it writes PC+4 back into the register file's PC. It also handles the boot PC load, redirects (branch/jump/trap) from execute, and fetch faults.

## Interface
- RESET_PC, 32'h0000_0000: PC value written into the register file after reset.
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pc  in  32  current PC, from the register file's program counter output.
- o_load_pc  out  1  PC write strobe to the register file.
- o_load_pc_data  out  32  PC write value.
- o_mem_req  out  1  instruction read request; held until ack.
- o_mem_addr  out  32  read address; registered, stable while o_mem_req.
- i_mem_ack  in  1  read complete; i_mem_data valid this cycle.
- i_mem_data  in  32  read data.
- i_mem_err  in  1  bus error; sampled with i_mem_ack.
- o_instr_valid  out  1  buffered instruction is valid.
- o_instr  out  32  buffered instruction word.
- o_instr_pc  out  32  address of o_instr.
- i_instr_ready  in  1  decode accepts o_instr.
- i_redirect  in  1  execute requests a PC change.
- i_redirect_pc  in  32  redirect target.
- o_fault  out  1  fetch fault pending; held until redirect.
- o_fault_pc  out  32  faulting fetch address.

## Operation
- States: BOOT, ISSUE, WAIT, HOLD, DRAIN, FAULT.
- BOOT:
  - o_load_pc=1 with RESET_PC.
  - Next state is ISSUE.
  - i_redirect is ignored.
- ISSUE:
  - If i_redirect: load i_redirect_pc and stay in ISSUE.
  - Else if i_pc[1:0]≠0: o_fault_pc←i_pc and go to FAULT.
  - Else: o_mem_addr←i_pc and go to WAIT.
- WAIT:
  - o_mem_req=1.
  - If i_redirect: load i_redirect_pc. Then go to ISSUE if i_mem_ack this cycle (data discarded); otherwise go to DRAIN.
  - Else if i_mem_ack & i_mem_err: o_fault_pc←o_mem_addr and go to FAULT.
  - Else if i_mem_ack: o_instr←i_mem_data, o_instr_pc←o_mem_addr, load o_mem_addr+4, then go to HOLD.
- HOLD:
  - o_instr_valid=1.
  - If i_redirect: load i_redirect_pc and go to ISSUE; the instruction is dropped even if i_instr_ready is high.
  - Else if i_instr_ready: go to ISSUE.
- DRAIN:
  - o_mem_req=1 until i_mem_ack, then go to ISSUE; response data and error are discarded.
  - A further i_redirect loads the PC and stays in DRAIN.
- FAULT:
  - o_fault=1.
  - No requests are issued.
  - i_redirect loads the PC and goes to ISSUE.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC→32'h0000_0000.
- Priority: i_redirect > i_mem_ack > i_instr_ready.
- The register file needs no reset of its own; BOOT initialises the PC.

## Timing
- State, o_mem_addr, o_instr, o_instr_pc and o_fault_pc are registers.
- o_mem_req, o_instr_valid and o_fault decode from state only.
- o_load_pc and o_load_pc_data are combinational from state and inputs. The register file captures them on the same edge as the state transition.
- Reset values:
  - State: BOOT.
  - o_load_pc=1, o_load_pc_data=RESET_PC (asserted throughout reset; harmless).
  - o_mem_req=0, o_mem_addr=0.
  - o_instr_valid=0, o_instr=0, o_instr_pc=0.
  - o_fault=0, o_fault_pc=0.
- Zero-wait memory:
  - Cycle sequence ISSUE→WAIT (ack)→HOLD, so o_instr_valid rises 2 cycles after ISSUE.
  - With ready tied high, throughput is 1 instruction per 3 cycles.
- o_mem_addr is constant from the first WAIT cycle until ack, including through DRAIN.
- Reset mid-transaction: state returns to BOOT immediately. A late ack arriving while in BOOT or ISSUE is ignored.

## Structure
- Package fetch_pkg holds:
  - the state enum fetch_state_t;
  - the localparam INSTR_BYTES=4.
- Single module. The datapath is small enough that no sub-module is warranted.

## Test plan
- Boot: release i_rst with RESET_PC=32'h0000_0100 and model the register file. Expect o_load_pc_data=32'h100 on the first edge, then o_mem_addr=32'h100 with o_mem_req=1.
- Stream: memory acks after 2 wait cycles with data 32'h0000_0013, ready held high. Expect o_instr_pc sequence 32'h100, 32'h104, 32'h108, and each o_instr=32'h13.
- Redirect during WAIT without ack: assert i_redirect with i_redirect_pc=32'h200. Expect state DRAIN, then the next request at 32'h200, and the old response never appears on o_instr.
- Redirect in HOLD with i_instr_ready high: expect o_instr_valid to drop and the next o_mem_addr=32'h200.
- Faults:
  - i_pc=32'h102 in ISSUE: expect o_fault=1, o_fault_pc=32'h102, no o_mem_req.
  - i_mem_err with ack at 32'h300: expect o_fault_pc=32'h300.
  - Recovery: redirect to 32'h400 clears o_fault and fetch resumes at 32'h400.
- Wrap: a fetch at 32'hFFFF_FFFC completes. Expect o_load_pc_data=32'h0000_0000.
